pdm_decoder: RTL

- Receive side of the 1-bit PDM audio link: converts a PDM bitstream back into unsigned amplitude samples.
- Used for on-chip loopback checking of the pdm modulator output, and for decoding external PDM sources such as PDM microphones on GPIO.
- Implementation: ORDER-stage CIC decimator, power-of-two decimation, saturating output scaler, one-cycle valid strobe.

---
 rtl/pdm_decoder_pkg.sv | 27 ++
 rtl/pdm_decoder_cic_integrator.sv | 25 ++
 rtl/pdm_decoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pdm_decoder_pkg.sv
// pdm_decoder_pkg: shared constants and types for the PDM receive path.
// Holds the default CIC geometry used by pdm_decoder and the amplitude type
// shared with the PDM modulator on the transmit side.
package pdm_decoder_pkg;

  // Amplitude word shared by the modulator input and the decoder output.
  localparam int AMPLITUDE_BITS = 24;
  typedef logic [AMPLITUDE_BITS-1:0] amplitude_t;

  // Default decimation: R = 2**PDM_DECIMATION_LOG2 input bits per sample.
  localparam int PDM_DECIMATION_LOG2 = 8;

  // Default number of CIC integrator/comb stages.
  localparam int CIC_ORDER = 3;

  // Internal CIC width: the full gain R**ORDER plus one bit, so that the
  // all-ones input (gain exactly 2**(W-1)) is still representable.
  function automatic int cic_width(input int order, input int dec_log2);
    return order * dec_log2 + 1;
  endfunction

  localparam int CIC_WIDTH = cic_width(CIC_ORDER, PDM_DECIMATION_LOG2);

  // Accumulator word for the default geometry.
  typedef logic [CIC_WIDTH-1:0] cic_acc;

endpackage

// File: rtl/pdm_decoder_cic_integrator.sv
// cic_integrator: one enabled, wrapping accumulator stage of the CIC
// decimator. Overflow wraps modulo 2**W on purpose; the comb section
// removes the wrap exactly, so saturating here would corrupt the output.
module cic_integrator
  import pdm_decoder_pkg::*;
#(
  parameter int W = CIC_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] x,
  output logic [W-1:0] acc
);

  // Accumulate the stage input on every enabled cycle, hold otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + x;
    end
  end

endmodule

// File: rtl/pdm_decoder.sv
// pdm_decoder: PDM bitstream to unsigned amplitude samples.
// ORDER-stage CIC decimator (registered integrator cascade, inline combs),
// decimation by R = 2**DECIMATION_LOG2, saturating scaler, one-cycle
// out_valid strobe one clock after each decimation tick.
// Optional build macro PDM_DECODER_SETTLE_EN: when defined, the first ORDER
// ticks after reset produce no out_valid and leave out at 0, hiding the
// partial values produced while the comb delays fill.
module pdm_decoder
  import pdm_decoder_pkg::*;
#(
  parameter int NBITS           = AMPLITUDE_BITS,
  parameter int ORDER           = CIC_ORDER,
  parameter int DECIMATION_LOG2 = PDM_DECIMATION_LOG2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             din,
  output logic [NBITS-1:0] out,
  output logic             out_valid
);

  localparam int W     = cic_width(ORDER, DECIMATION_LOG2);
  localparam int SHIFT = W - 1 - NBITS;

  localparam logic [DECIMATION_LOG2-1:0] CNT_LAST = '1;
  localparam logic [W-1:0]               D_FULL   = {1'b1, {(W-1){1'b0}}};

  if (ORDER < 1 || ORDER > 5) begin : g_bad_order
    $error("pdm_decoder: ORDER must be in 1..5");
  end
  if (ORDER * DECIMATION_LOG2 < NBITS) begin : g_bad_width
    $error("pdm_decoder: ORDER*DECIMATION_LOG2 must be >= NBITS");
  end

  logic [W-1:0] integ    [ORDER];
  logic [W-1:0] integ_in [ORDER];

  // Registered cascade: each stage adds the previous stage's old value.
  for (genvar k = 0; k < ORDER; k++) begin : g_integ
    if (k == 0) begin : g_first
      assign integ_in[k] = W'(din);
    end else begin : g_next
      assign integ_in[k] = integ[k-1];
    end

    cic_integrator #(
      .W(W)
    ) u_integ (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .x      (integ_in[k]),
      .acc    (integ[k])
    );
  end

  logic [DECIMATION_LOG2-1:0] dec_cnt;
  logic                       tick;

  assign tick = enable && (dec_cnt == CNT_LAST);

  // Decimation counter: counts enabled bits, wraps R-1 -> 0 naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (enable) begin
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

  // Comb chain is combinational from the last integrator's current value;
  // only the delay registers are clocked, and only on a tick.
  logic [W-1:0] comb_prev [ORDER];
  logic [W-1:0] comb_x    [ORDER+1];

  assign comb_x[0] = integ[ORDER-1];

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    assign comb_x[k+1] = comb_x[k] - comb_prev[k];
  end

  // Comb delay update: each stage remembers its input from this tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) begin
        comb_prev[k] <= '0;
      end
    end else if (tick) begin
      for (int k = 0; k < ORDER; k++) begin
        comb_prev[k] <= comb_x[k];
      end
    end
  end

  // Scaling: the comb output tops out at exactly 2**(W-1) for an all-ones
  // stream; that single value would wrap to 0 after truncation, so clamp it.
  logic [W-1:0]     comb_d;
  logic [NBITS-1:0] scaled;

  assign comb_d = comb_x[ORDER];

  // Saturating shift of the comb output down to NBITS.
  always_comb begin
    scaled = comb_d[W-2:SHIFT];
    if (comb_d == D_FULL) begin
      scaled = '1;
    end
  end

  logic settled;

`ifdef PDM_DECODER_SETTLE_EN
  logic [2:0] settle_cnt;

  assign settled = (settle_cnt == 3'(ORDER));

  // Count ticks after reset until the comb delays hold real history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (tick && !settled) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end
`else
  assign settled = 1'b1;
`endif

  // Output register: new sample and strobe on the edge that ends a tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= tick && settled;
      if (tick) begin
        out <= settled ? scaled : '0;
      end
    end
  end

endmodule
